spi_reg_slave: RTL and testbench
================================

// Module: spi_reg_slave
// PURPOSE
//  SPI mode-0 responder with a small byte-wide register file. It is the device side of the
//  ADXL355-style transactions issued by the spi/spi_wr initiators in top.
//  It emulates the sensor on the FPGA, so the UART/SPI readout path runs loopback tests
//  without hardware.
//  All SPI pins are oversampled in the clk domain; no logic runs on sclk.
// PARAMETERS
//  NUM_REGS     16      register count; addresses >= NUM_REGS read 8'h00, writes are ignored
//  DEVID        8'hAD   fixed, read-only contents of address 0
//  SYNC_STAGES  2       flip-flop synchroniser depth on sclk, mosi and cs_n (minimum 2)
// PORTS
//  clk           in   1  system clock (42 MHz); sclk must be <= clk/8
//  rst_n         in   1  asynchronous, active-low reset
//  sclk          in   1  SPI clock from initiator; idles low (CPOL=0)
//  cs_n          in   1  SPI chip select, active low
//  mosi          in   1  SPI data in, sampled on sclk rising edge
//  miso          out  1  SPI data out, updated after sclk falling edge
//  miso_oe       out  1  1 while synchronised cs_n is low (tristate control)
//  host_wr_en    in   1  local register write strobe
//  host_wr_addr  in   4  local write address
//  host_wr_data  in   8  local write data
//  spi_wr_valid  out  1  one-clk pulse for each register byte written over SPI
//  spi_wr_addr   out  4  address of that write
//  spi_wr_data   out  8  data of that write
//  frame_done    out  1  one-clk pulse when cs_n rises after >= 1 complete byte
//  busy          out  1  high from synchronised cs_n fall to cs_n rise
// BEHAVIOUR
//  Reset values: miso=0, miso_oe=0, spi_wr_valid=0, frame_done=0, busy=0, state=IDLE,
//    registers=8'h00, reg[0]=DEVID.
//  Synchronise sclk, mosi and cs_n through SYNC_STAGES flops. Detect sclk rise/fall as
//    sync vs one-cycle-delayed sync.
//  Frame: byte 0 is the command {addr[6:0], rw}, MSB first; rw=1 means read.
//    Every following byte is data. The address auto-increments after each data byte and
//    wraps from NUM_REGS-1 to 0.
//  FSM states: IDLE -> CMD on cs_n fall. CMD -> READ or WRITE on the 8th rising edge.
//    READ and WRITE stay until cs_n rises. Any state -> IDLE on cs_n rise.
//  Bit counter is 3 bits. Each rising edge shifts mosi into rx_shift, MSB first.
//    Bit 7 completes the byte and the counter wraps to 0.
//  READ:
//    - Load tx_shift with reg[addr] on the 8th cmd rising edge and after each data byte.
//    - Drive miso = tx_shift[7] from the next falling edge on; shift left on each falling edge.
//    - Latency: miso is valid SYNC_STAGES+1 clks after the sclk falling edge.
//    - During CMD, miso=0.
//  WRITE:
//    - On the 8th data rising edge, write reg[addr] (unless addr==0 or addr>=NUM_REGS).
//    - Pulse spi_wr_valid with addr/data in the same cycle.
//    - Writes to addr 0 still pulse spi_wr_valid; reg[0] is unchanged.
//  host_wr_en writes any addr except 0.
//    If it collides with an SPI write in the same clk to the same addr, the SPI write wins.
//  cs_n rises mid-byte: discard the partial byte (no write, no pulse) and return to IDLE.
//    frame_done pulses only if >= 1 whole byte completed.
//  cs_n low with no sclk edges: stay in CMD, no side effects.
//  Asynchronous reset mid-frame: outputs go to reset values at once.
//    The next frame starts in CMD only at a fresh cs_n falling edge seen after reset.
//  Address arithmetic: 7-bit command address. Only addresses < NUM_REGS hit storage.
//    Increment is modulo NUM_REGS.
// STRUCTURE
//  Shared package spi_pkg: SPI_CMD_RW bit index (0), the state enum {IDLE,CMD,READ,WRITE},
//    and DEVID_DEFAULT.
//  One sub-module: spi_pin_sync, an N-stage synchroniser plus rise/fall edge detector,
//    instantiated for sclk, mosi and cs_n.
//  The register file stays inline (flops, NUM_REGS x 8).
// TESTING
//  Read DEVID: cmd 8'h01, then 1 byte at sclk=clk/8 -> miso byte 8'hAD; frame_done pulses
//    once after cs_n rises.
//  Write burst: cmd 8'h06 (addr 3, write), data 8'h11, 8'h22
//    -> spi_wr_valid twice: (3,8'h11), (4,8'h22). A later read of addr 3 for 2 bytes
//    returns 8'h11, 8'h22.
//  Wrap: host writes reg15=8'h5A; SPI read from addr 15 for 2 bytes -> 8'h5A, then 8'hAD
//    (wrapped to addr 0).
//  Abort: cs_n rises after 4 bits of a write data byte -> no spi_wr_valid, register
//    unchanged, state IDLE; frame_done pulses (cmd byte completed).
//  Collision: host_wr_en addr 5 = 8'hFF in the same clk as an SPI write addr 5 = 8'h33
//    -> reg5 = 8'h33.
//  Reset: assert rst_n low during a read data byte -> miso=0 and miso_oe=0 immediately;
//    release while cs_n is held low -> no response until the next cs_n fall.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants and FSM state type for the SPI register slave.
// Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Bit position of the read/write flag inside the command byte.
    localparam int SPI_CMD_RW = 0;

    // Fixed device identifier returned from address 0.
    localparam logic [7:0] DEVID_DEFAULT = 8'hAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Brief    : N-stage flip-flop synchroniser with rise/fall edge detection.
// Revision : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              dly_q;

    // Shift the pin through the chain; keep one extra delayed copy for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VAL}};
            dly_q   <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], pin_i};
            dly_q   <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~dly_q;
    assign fall_o = ~chain_q[STAGES-1] & dly_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave
// Brief    : SPI mode-0 responder with a byte-wide register file. All SPI pins
//            are oversampled in the clk domain.
// Revision : 1.0  initial release
// ============================================================================
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] DEVID       = DEVID_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       host_wr_en,
    input  logic [3:0] host_wr_addr,
    input  logic [7:0] host_wr_data,
    output logic       spi_wr_valid,
    output logic [3:0] spi_wr_addr,
    output logic [7:0] spi_wr_data,
    output logic       frame_done,
    output logic       busy
);

    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_s, cs_rise, cs_fall;

    // The cs_n chain resets low: if cs_n is still held low when reset is
    // released no falling edge is seen, so the slave waits for a fresh frame.
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin_i(sclk),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin_i(mosi),
        .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin_i(cs_n),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));

    logic unused_sync;
    assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall, cs_s};

    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] addr_q, addr_d;
    logic       byte_seen_q, byte_seen_d;
    logic       miso_q, miso_d;
    logic       frame_done_q, frame_done_d;
    logic       wr_valid_q, wr_valid_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [7:0] regs_q [NUM_REGS];

    logic [7:0] byte_w;
    logic [6:0] addr_nxt;
    logic [6:0] rd_sel;
    logic [7:0] rd_data;
    logic       spi_we;

    assign byte_w   = {rx_q, mosi_s};
    assign addr_nxt = (addr_q >= NUM_REGS_A - 7'd1) ? 7'd0 : addr_q + 7'd1;
    // In CMD the byte being completed carries the start address; otherwise
    // the next sequential address is prefetched.
    assign rd_sel   = (state_q == CMD) ? byte_w[7:1] : addr_nxt;
    assign rd_data  = (rd_sel < NUM_REGS_A) ? regs_q[rd_sel[AW-1:0]] : 8'h00;

    // Frame sequencing: command decode, read shifting and write commits.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        byte_seen_d  = byte_seen_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        spi_we       = 1'b0;

        if (cs_rise) begin
            // Any partial byte is simply dropped here.
            frame_done_d = (state_q != IDLE) && byte_seen_q;
            state_d      = IDLE;
            bit_cnt_d    = 3'd0;
            byte_seen_d  = 1'b0;
            miso_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d     = CMD;
                        bit_cnt_d   = 3'd0;
                        byte_seen_d = 1'b0;
                        miso_d      = 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d      = byte_w[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_seen_d = 1'b1;
                            addr_d      = byte_w[7:1];
                            if (byte_w[SPI_CMD_RW]) begin
                                state_d = READ;
                                tx_d    = rd_data;
                            end else begin
                                state_d = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_d      = byte_w[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = addr_nxt;
                            tx_d   = rd_data;
                        end
                    end
                end
                WRITE: begin
                    if (sclk_rise) begin
                        rx_d      = byte_w[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q[3:0];
                            wr_data_d  = byte_w;
                            spi_we     = (addr_q != 7'd0) && (addr_q < NUM_REGS_A);
                            addr_d     = addr_nxt;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'h00;
            addr_q       <= 7'd0;
            byte_seen_q  <= 1'b0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            byte_seen_q  <= byte_seen_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Register file: entry 0 holds DEVID permanently; SPI beats host on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? DEVID : 8'h00;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (spi_we && (addr_q[AW-1:0] == AW'(i))) begin
                    regs_q[i] <= byte_w;
                end else if (host_wr_en && (host_wr_addr == 4'(i))) begin
                    regs_q[i] <= host_wr_data;
                end
            end
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = (state_q != IDLE);
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign spi_wr_valid = wr_valid_q;
    assign spi_wr_addr  = wr_addr_q;
    assign spi_wr_data  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_slave
// Brief    : Scoreboard bench for spi_reg_slave with a register-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic       host_wr_en = 1'b0;
    logic [3:0] host_wr_addr = 4'd0;
    logic [7:0] host_wr_data = 8'h00;
    logic       spi_wr_valid;
    logic [3:0] spi_wr_addr;
    logic [7:0] spi_wr_data;
    logic       frame_done, busy;

    spi_reg_slave dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .spi_wr_valid(spi_wr_valid), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mregs [16];
    logic [7:0]  fdata [16];
    logic [11:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  obs_rd [$];
    int          fd_exp  = 0;
    int          fd_seen = 0;
    logic [3:0]  coll_addr;
    logic [7:0]  coll_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] mread(input logic [6:0] a);
        return (a < 7'd16) ? mregs[a[3:0]] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mregs[0] = 8'hAD;
    endtask

    // Write-event monitor.
    always @(negedge clk) begin
        if (spi_wr_valid) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", {20'd0, spi_wr_addr, spi_wr_data}, 32'hFFFFFFFF);
            else chk("wr_event", {20'd0, spi_wr_addr, spi_wr_data}, {20'd0, exp_wr.pop_front()});
        end
    end

    // Read-byte monitor.
    always @(negedge clk) begin
        if (obs_rd.size() != 0) begin
            logic [7:0] g;
            g = obs_rd.pop_front();
            if (exp_rd.size() == 0) chk("rd_unexpected", {24'd0, g}, 32'hFFFFFFFF);
            else chk("rd_byte", {24'd0, g}, {24'd0, exp_rd.pop_front()});
        end
    end

    // frame_done pulse counter.
    always @(negedge clk) if (frame_done) fd_seen++;

    task automatic spi_bit(input logic b, output logic m, input logic coll);
        mosi = b;
        repeat (4) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        if (coll) begin
            host_wr_en = 1'b1; host_wr_addr = coll_addr; host_wr_data = coll_data;
        end
        @(negedge clk);
        host_wr_en = 1'b0;
        @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
        if (a != 4'd0) mregs[a] = d;
    endtask

    // nb < 0: abort inside the command byte after part_bits bits.
    task automatic frame(input logic [7:0] cmd, input int nb, input int part_bits, input int coll_byte);
        logic [6:0] a;
        logic [7:0] cur, rb;
        logic       m;
        int         nbits, bi, bt, full;
        a = cmd[7:1];
        full = (nb < 0) ? 0 : nb + 1;
        for (int k = 0; k < nb; k++) begin
            if (cmd[0]) exp_rd.push_back(mread(a));
            else begin
                exp_wr.push_back({a[3:0], fdata[k]});
                if (a != 7'd0 && a < 7'd16) mregs[a[3:0]] = fdata[k];
            end
            a = (a + 7'd1) % 7'd16;
        end
        if (full >= 1) fd_exp++;
        nbits = (nb < 0) ? part_bits : 8 * (nb + 1) + part_bits;
        rb = 8'h00;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        chk("oe_in_frame", {31'd0, miso_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            bi  = i / 8;
            bt  = 7 - (i % 8);
            cur = (bi == 0) ? cmd : fdata[bi-1];
            spi_bit(cur[bt], m, (coll_byte >= 0) && (bi - 1 == coll_byte) && (bt == 0));
            if (bi > 0) begin
                rb = {rb[6:0], m};
                if (bt == 0 && cmd[0]) obs_rd.push_back(rb);
            end
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("frame_done_count", fd_seen, fd_exp);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("wr_pending", exp_wr.size(), 0);
        chk("rd_pending", exp_rd.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       m;
        logic [7:0] cmd;
        int         nb, pb;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_valid", {31'd0, spi_wr_valid}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // DEVID read.
        frame(8'h01, 1, 0, -1);
        // Write burst to 3,4 then read back.
        fdata[0] = 8'h11; fdata[1] = 8'h22;
        frame(8'h06, 2, 0, -1);
        frame(8'h07, 2, 0, -1);
        // Wrap from 15 to 0.
        host_write(4'd15, 8'h5A);
        frame(8'h1F, 2, 0, -1);
        // Abort mid data byte of a write to addr 7, then read addr 7.
        fdata[0] = 8'hC3;
        frame(8'h0E, 0, 4, -1);
        frame(8'h0F, 1, 0, -1);
        // Abort inside the command byte: no frame_done.
        frame(8'h0F, -1, 3, -1);
        // cs_n low with no clocks.
        cs_n = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_cs_busy", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_cs_fd", fd_seen, fd_exp);
        // Collision: host FF vs SPI 33 at addr 5.
        coll_addr = 4'd5; coll_data = 8'hFF;
        fdata[0] = 8'h33;
        frame(8'h0A, 1, 0, 0);
        frame(8'h0B, 1, 0, -1);
        // Address 0 is read-only from both sides.
        host_write(4'd0, 8'h55);
        fdata[0] = 8'h77;
        frame(8'h00, 1, 0, -1);
        frame(8'h01, 1, 0, -1);
        // Out-of-range read.
        frame(8'h51, 1, 0, -1);

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            cmd = {3'd0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
            nb  = $urandom_range(1, 4);
            pb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 5; k++) fdata[k] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) host_write(4'($urandom_range(1, 15)), 8'($urandom));
            frame(cmd, nb, pb, -1);
        end

        // Reset during a read data byte.
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        cmd = 8'h01;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], m, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_reset_miso", {31'd0, miso}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_miso", {31'd0, miso}, 32'd0);
        chk("async_rst_oe", {31'd0, miso_oe}, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 15; i >= 0; i--) spi_bit(1'b1, m, 1'b0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("post_rst_miso", {31'd0, miso}, 32'd0);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_fd", fd_seen, fd_exp);
        frame(8'h07, 1, 0, -1);
        frame(8'h01, 1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
